breathe_pwm_multi: RTL

- Multi-channel LED "breathing" PWM generator with parametrised PWM resolution, index-table depth and channel count.
- A shared PWM counter drives all channels. One shared sine-squared (raised-cosine) index sequencer also serves all channels; each channel reads it at a fixed phase offset.
- Adds run-time modes (breathe/static/blink/off), a programmable step prescaler, a synchronous restart, and glitch-free duty/enable updates at period boundaries.
- Sits between board switches/control logic and LED pins, clocked by sysclk.

---
 rtl/breathe_pkg.sv | 44 ++++
 rtl/breathe_pwm_multi_if.sv | 26 ++
 rtl/breathe_lut.sv | 21 ++
 rtl/breathe_pwm_multi.sv | 102 ++++++++++
 4 files changed

// File: rtl/breathe_pkg.sv
// Shared definitions for the breathing PWM block: mode encodings and the
// elaboration-time helpers that build the raised-cosine table and channel phases.
package breathe_pkg;

    typedef enum logic [1:0] {
        MODE_BREATHE = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    localparam real PI = 3.14159265358979323846;

    // Taylor series after folding the angle into [-pi, pi]; only ever evaluated at elaboration.
    function automatic real cos_approx(real x);
        real xr;
        real term;
        real sum;
        xr   = (x > PI) ? (x - 2.0 * PI) : x;
        term = 1.0;
        sum  = 1.0;
        for (int k = 1; k <= 20; k++) begin
            term = -term * xr * xr / real'((2 * k - 1) * (2 * k));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // The small epsilon keeps exact .5 points (e.g. the quarter-breath) rounding up.
    function automatic int lut_value(int i, int pwm_w, int idx_w);
        real full;
        real ang;
        real v;
        full = real'((1 << pwm_w) - 1);
        ang  = 2.0 * PI * real'(i) / real'(1 << idx_w);
        v    = full * (1.0 - cos_approx(ang)) / 2.0;
        return $rtoi(v + 0.5 + 1.0e-6);
    endfunction

    function automatic int ch_offset(int c, int channels, int idx_w);
        return (c * ((1 << idx_w) / channels)) % (1 << idx_w);
    endfunction

endpackage

// File: rtl/breathe_pwm_multi_if.sv
// Control and output bundle of the breathing PWM generator.
interface breathe_pwm_multi_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_W    = 6,
    parameter int PRESC_W  = 8
);
    logic [CHANNELS-1:0] enable;
    logic [1:0]          mode;
    logic [PRESC_W-1:0]  step_div;
    logic [PWM_W-1:0]    static_level;
    logic                sync_restart;
    logic [CHANNELS-1:0] pulse;
    logic                period_tick;

    // No valid/ready pair: every input is a level sampled on each sysclk edge,
    // with enable/mode only taking effect at the period boundary.
    modport master (
        output enable, mode, step_div, static_level, sync_restart,
        input  pulse, period_tick
    );

    modport slave (
        input  enable, mode, step_div, static_level, sync_restart,
        output pulse, period_tick
    );
endinterface

// File: rtl/breathe_lut.sv
// Combinational raised-cosine lookup: index -> duty, table fixed at elaboration.
module breathe_lut
    import breathe_pkg::*;
#(
    parameter int PWM_W = 6,
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx,
    output logic [PWM_W-1:0] level
);

    logic [PWM_W-1:0] rom [2**IDX_W];

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_rom
        localparam int VALUE = lut_value(i, PWM_W, IDX_W);
        assign rom[i] = VALUE[PWM_W-1:0];
    end

    assign level = rom[idx];

endmodule

// File: rtl/breathe_pwm_multi.sv
// Multi-channel breathing PWM: shared counter and index sequencer, per-channel
// phase-offset table lookup, duty/enable reloaded only at period boundaries.
module breathe_pwm_multi
    import breathe_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_W    = 6,
    parameter int IDX_W    = 6,
    parameter int PRESC_W  = 8
) (
    input logic                sysclk,
    input logic                rst_n,
    breathe_pwm_multi_if.slave bus
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0]                   count;
    logic [PRESC_W-1:0]                 presc;
    logic [IDX_W-1:0]                   base_idx;
    logic [CHANNELS-1:0][PWM_W-1:0]     duty_q;
    logic [CHANNELS-1:0]                en_q;
    logic [CHANNELS-1:0][PWM_W-1:0]     duty_src;
    logic [CHANNELS-1:0]                pulse_c;
    logic                               boundary;
    mode_e                              mode;

    assign boundary = (count == CNT_MAX);
    assign mode     = mode_e'(bus.mode);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [IDX_W-1:0] OFS = IDX_W'(ch_offset(c, CHANNELS, IDX_W));

        logic [IDX_W-1:0] ch_idx;
        logic [PWM_W-1:0] lut_level;
        logic [PWM_W-1:0] src;

        assign ch_idx = base_idx + OFS;

        breathe_lut #(
            .PWM_W (PWM_W),
            .IDX_W (IDX_W)
        ) u_lut (
            .idx   (ch_idx),
            .level (lut_level)
        );

        always_comb begin
            src = '0;
            unique case (mode)
                MODE_BREATHE: src = lut_level;
                MODE_STATIC:  src = bus.static_level;
                MODE_BLINK:   src = ch_idx[IDX_W-1] ? '1 : '0;
                MODE_OFF:     src = '0;
                default:      src = '0;
            endcase
        end

        assign duty_src[c] = src;
    end

    // Strict compare keeps the top duty one cycle short of 100% and duty 0 always low.
    always_comb begin
        pulse_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pulse_c[c] = en_q[c] && (count < duty_q[c]);
        end
    end

    assign bus.pulse       = pulse_c;
    assign bus.period_tick = boundary;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            presc    <= '0;
            base_idx <= '0;
            duty_q   <= '0;
            en_q     <= '0;
        end else if (bus.sync_restart) begin
            count    <= '0;
            presc    <= '0;
            base_idx <= '0;
            duty_q   <= '0;
            en_q     <= '0;
        end else begin
            count <= count + 1'b1;
            if (boundary) begin
                en_q   <= bus.enable;
                duty_q <= duty_src;
                // >= so that shrinking step_div mid-count steps at once instead of wrapping presc.
                if (presc >= bus.step_div) begin
                    presc    <= '0;
                    base_idx <= base_idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule
